// File: rtl/datamem_pkg.sv
// ----------------------------------------------------------------------------
// datamem_pkg
// Shared definitions for the byte-addressable data memory: access-size
// encoding, word geometry and the request legality check used by both the
// storage top level and any future clients that want to pre-screen requests.
// ----------------------------------------------------------------------------
package datamem_pkg;

   // Access size as carried on the request size field
   typedef enum logic [1:0] {
      SIZE_B   = 2'b00,
      SIZE_H   = 2'b01,
      SIZE_W   = 2'b10,
      SIZE_RSV = 2'b11
   } mem_size_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
   localparam int unsigned OFFSET_W   = $clog2(WORD_BYTES);

   // A request is illegal for the reserved size or when it is not naturally aligned
   function automatic logic access_error(input mem_size_t sz, input logic [OFFSET_W-1:0] offset);
      logic bad;
      bad = 1'b1;
      case (sz)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = offset[0];
         SIZE_W:  bad = |offset;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte lanes touched by a legal access at the given word offset
   function automatic logic [WORD_BYTES-1:0] lane_mask(input mem_size_t sz, input logic [OFFSET_W-1:0] offset);
      logic [WORD_BYTES-1:0] mask;
      mask = '0;
      case (sz)
         SIZE_B:  mask = WORD_BYTES'(1) << offset;
         SIZE_H:  mask = offset[1] ? WORD_BYTES'(4'b1100) : WORD_BYTES'(4'b0011);
         SIZE_W:  mask = '1;
         default: mask = '0;
      endcase
      return mask;
   endfunction

endpackage : datamem_pkg

// File: rtl/load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Combinational load alignment: picks the addressed byte or half out of a
// raw little-endian storage word and sign- or zero-extends it to 32 bits.
// Word accesses pass through untouched (extension mode is irrelevant).
//
// Ports
//   raw         in  32  storage word read at the access's word index
//   offset      in   2  addr[1:0] of the access
//   size        in   2  access size (mem_size_t)
//   unsigned_ld in   1  1 = zero-extend, 0 = sign-extend
//   value       out 32  aligned, extended load result
// ----------------------------------------------------------------------------
module load_extend
   import datamem_pkg::*;
(
   input  logic [WORD_W-1:0]   raw,
   input  logic [OFFSET_W-1:0] offset,
   input  mem_size_t           size,
   input  logic                unsigned_ld,
   output logic [WORD_W-1:0]   value
);

   localparam int unsigned HALF_W = 2 * BYTE_W;

   logic [BYTE_W-1:0] sel_byte;
   logic [HALF_W-1:0] sel_half;
   logic              byte_fill;
   logic              half_fill;

   // Lane selection driven by the low address bits
   always_comb begin
      sel_byte = raw[BYTE_W-1:0];
      case (offset)
         2'd0: sel_byte = raw[ 7: 0];
         2'd1: sel_byte = raw[15: 8];
         2'd2: sel_byte = raw[23:16];
         2'd3: sel_byte = raw[31:24];
         default: sel_byte = raw[7:0];
      endcase
      sel_half = offset[1] ? raw[31:16] : raw[15:0];
   end

   assign byte_fill = ~unsigned_ld & sel_byte[BYTE_W-1];
   assign half_fill = ~unsigned_ld & sel_half[HALF_W-1];

   // Extension; the reserved size never reaches the output register
   always_comb begin
      value = '0;
      case (size)
         SIZE_B:  value = {{(WORD_W-BYTE_W){byte_fill}}, sel_byte};
         SIZE_H:  value = {{(WORD_W-HALF_W){half_fill}}, sel_half};
         SIZE_W:  value = raw;
         default: value = '0;
      endcase
   end

endmodule : load_extend

// File: rtl/byte_datamem.sv
// ----------------------------------------------------------------------------
// byte_datamem
// Byte-addressable data memory with byte/half/word loads and stores.
// One request per cycle, no back-pressure. Loads return one cycle later
// through a registered, extended rd with a one-cycle rd_valid pulse;
// misaligned or reserved-size requests produce a one-cycle err pulse and
// never touch storage. Storage is not reset.
//
// Ports
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   synchronous active-high reset (outputs only)
//   req_valid   in   1   request present this cycle
//   wr_en       in   1   1 = store, 0 = load
//   size        in   2   00 byte, 01 half, 10 word, 11 reserved
//   unsigned_ld in   1   load extension: 1 zero, 0 sign
//   addr        in   AW  byte address
//   wd          in   DW  right-aligned store data
//   rd          out  DW  registered load data
//   rd_valid    out  1   rd updated this cycle
//   err         out  1   previous request was illegal
// ----------------------------------------------------------------------------
module byte_datamem
   import datamem_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic                     wr_en,
   input  logic [1:0]               size,
   input  logic                     unsigned_ld,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wd,
   output logic [DATA_WIDTH-1:0]    rd,
   output logic                     rd_valid,
   output logic                     err
);

   // Only a 32-bit data path is implemented
   if (DATA_WIDTH != WORD_W) begin : g_bad_width
      $error("byte_datamem: DATA_WIDTH must be 32");
   end

   localparam int unsigned INDEX_W = ADDRESS_WIDTH - OFFSET_W;
   localparam int unsigned DEPTH   = 2 ** INDEX_W;

   mem_size_t             req_size;
   logic [INDEX_W-1:0]    word_idx;
   logic [OFFSET_W-1:0]   offset;
   logic                  bad_c;
   logic                  accept_c;
   logic                  store_ok_c;
   logic                  load_ok_c;
   logic [WORD_BYTES-1:0] lane_we_c;
   logic [WORD_W-1:0]     lane_wdata_c;
   logic [WORD_W-1:0]     raw_word_c;
   logic [WORD_W-1:0]     ld_value_c;

   assign req_size = mem_size_t'(size);
   assign word_idx = addr[ADDRESS_WIDTH-1:OFFSET_W];
   assign offset   = addr[OFFSET_W-1:0];

   // Request qualification; a reset cycle swallows the request entirely
   assign bad_c      = access_error(req_size, offset);
   assign accept_c   = req_valid & ~rst;
   assign store_ok_c = accept_c &  wr_en & ~bad_c;
   assign load_ok_c  = accept_c & ~wr_en & ~bad_c;

   // Store data replicated so every lane sees its little-endian byte
   always_comb begin
      lane_wdata_c = wd[WORD_W-1:0];
      case (req_size)
         SIZE_B:  lane_wdata_c = {WORD_BYTES{wd[BYTE_W-1:0]}};
         SIZE_H:  lane_wdata_c = {2{wd[2*BYTE_W-1:0]}};
         default: lane_wdata_c = wd[WORD_W-1:0];
      endcase
      lane_we_c = store_ok_c ? lane_mask(req_size, offset) : '0;
   end

   // Four independent byte lanes sharing one word index
   for (genvar l = 0; l < WORD_BYTES; l++) begin : g_lane
      logic [BYTE_W-1:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
         if (lane_we_c[l]) begin
            lane_mem[word_idx] <= lane_wdata_c[l*BYTE_W +: BYTE_W];
         end
      end

      // Read of the already-committed array, so a store one cycle earlier is visible
      assign raw_word_c[l*BYTE_W +: BYTE_W] = lane_mem[word_idx];
   end

   load_extend u_load_extend (
      .raw         (raw_word_c),
      .offset      (offset),
      .size        (req_size),
      .unsigned_ld (unsigned_ld),
      .value       (ld_value_c)
   );

   // Output registers; rd only moves on a legal load
   always_ff @(posedge clk) begin
      if (rst) begin
         rd       <= '0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         rd_valid <= load_ok_c;
         err      <= accept_c & bad_c;
         if (load_ok_c) begin
            rd <= DATA_WIDTH'(ld_value_c);
         end
      end
   end

endmodule : byte_datamem

// File: tb/tb_byte_datamem.sv
// ----------------------------------------------------------------------------
// tb_byte_datamem
// Directed bench for byte_datamem: linear request sequence with
// hand-computed expected rd / rd_valid / err after each request.
// ----------------------------------------------------------------------------
module tb_byte_datamem;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        wr_en;
   logic [1:0]  size;
   logic        unsigned_ld;
   logic [15:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        rd_valid;
   logic        err;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

   byte_datamem #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .wr_en       (wr_en),
      .size        (size),
      .unsigned_ld (unsigned_ld),
      .addr        (addr),
      .wd          (wd),
      .rd          (rd),
      .rd_valid    (rd_valid),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one cycle of inputs, then return 1 time unit after the capturing edge
   task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                        input logic u, input logic [15:0] a, input logic [31:0] d);
      req_valid   = v;
      wr_en       = w;
      size        = sz;
      unsigned_ld = u;
      addr        = a;
      wd          = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Checks all three outputs after a request
   task automatic expect_out(input string tag, input logic [31:0] exp_rd,
                             input logic exp_v, input logic exp_e);
      check({tag, ".rd"},       rd,               exp_rd);
      check({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, exp_v});
      check({tag, ".err"},      {31'd0, err},      {31'd0, exp_e});
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, SZ_B, 1'b0, 16'h0000, 32'h0);
      drive(1'b0, 1'b0, SZ_B, 1'b0, 16'h0000, 32'h0);
      expect_out("reset", 32'h0, 1'b0, 1'b0);

      rst = 1'b0;
      // Seed bytes used later by the reset-preservation step
      drive(1'b1, 1'b1, SZ_B, 1'b0, 16'h0020, 32'hFFFF_FF5A);
      expect_out("st_b20", 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, SZ_B, 1'b0, 16'h0021, 32'h0000_0080);
      drive(1'b1, 1'b0, SZ_B, 1'b0, 16'h0021, 32'h0);
      expect_out("ld_b21_s", 32'hFFFF_FF80, 1'b1, 1'b0);

      // Word store then word load
      drive(1'b1, 1'b1, SZ_W, 1'b0, 16'h0010, 32'hDEAD_BEEF);
      expect_out("st_w10", 32'hFFFF_FF80, 1'b0, 1'b0);
      drive(1'b1, 1'b0, SZ_W, 1'b0, 16'h0010, 32'h0);
      expect_out("ld_w10", 32'hDEAD_BEEF, 1'b1, 1'b0);
      drive(1'b0, 1'b0, SZ_W, 1'b0, 16'h0010, 32'h0);
      expect_out("idle_hold", 32'hDEAD_BEEF, 1'b0, 1'b0);

      // Byte loads with both extensions
      drive(1'b1, 1'b0, SZ_B, 1'b0, 16'h0013, 32'h0);
      expect_out("ld_b13_s", 32'hFFFF_FFDE, 1'b1, 1'b0);
      drive(1'b1, 1'b0, SZ_B, 1'b1, 16'h0013, 32'h0);
      expect_out("ld_b13_u", 32'h0000_00DE, 1'b1, 1'b0);

      // Half store, upper wd bits must be ignored, then immediate word load
      drive(1'b1, 1'b1, SZ_H, 1'b0, 16'h0012, 32'hFFFF_1234);
      expect_out("st_h12", 32'h0000_00DE, 1'b0, 1'b0);
      drive(1'b1, 1'b0, SZ_W, 1'b0, 16'h0010, 32'h0);
      expect_out("ld_w10_raw", 32'h1234_BEEF, 1'b1, 1'b0);

      drive(1'b1, 1'b0, SZ_H, 1'b0, 16'h0010, 32'h0);
      expect_out("ld_h10_s", 32'hFFFF_BEEF, 1'b1, 1'b0);
      drive(1'b1, 1'b0, SZ_H, 1'b1, 16'h0010, 32'h0);
      expect_out("ld_h10_u", 32'h0000_BEEF, 1'b1, 1'b0);
      drive(1'b1, 1'b0, SZ_H, 1'b0, 16'h0012, 32'h0);
      expect_out("ld_h12_s", 32'h0000_1234, 1'b1, 1'b0);
      drive(1'b1, 1'b0, SZ_B, 1'b0, 16'h0011, 32'h0);
      expect_out("ld_b11_s", 32'hFFFF_FFBE, 1'b1, 1'b0);
      drive(1'b1, 1'b1, SZ_W, 1'b1, 16'h0010, 32'h0);
      drive(1'b1, 1'b0, SZ_W, 1'b1, 16'h0010, 32'h0);
      expect_out("ld_w10_zero", 32'h0000_0000, 1'b1, 1'b0);
      drive(1'b1, 1'b1, SZ_W, 1'b0, 16'h0010, 32'hDEAD_BEEF);
      drive(1'b1, 1'b0, SZ_W, 1'b1, 16'h0010, 32'h0);
      expect_out("ld_w10_u_ignored", 32'hDEAD_BEEF, 1'b1, 1'b0);

      // Misaligned half load and word store
      drive(1'b1, 1'b1, SZ_W, 1'b0, 16'h0014, 32'hCAFE_F00D);
      drive(1'b1, 1'b0, SZ_H, 1'b0, 16'h0011, 32'h0);
      expect_out("ld_h11_mis", 32'hDEAD_BEEF, 1'b0, 1'b1);
      drive(1'b1, 1'b1, SZ_W, 1'b0, 16'h0016, 32'h1122_3344);
      expect_out("st_w16_mis", 32'hDEAD_BEEF, 1'b0, 1'b1);
      drive(1'b1, 1'b0, SZ_W, 1'b0, 16'h0014, 32'h0);
      expect_out("ld_w14_intact", 32'hCAFE_F00D, 1'b1, 1'b0);

      // Reserved size, load and store; storage untouched
      drive(1'b1, 1'b0, SZ_R, 1'b0, 16'h0010, 32'h0);
      expect_out("ld_rsv", 32'hCAFE_F00D, 1'b0, 1'b1);
      drive(1'b1, 1'b1, SZ_R, 1'b0, 16'h0010, 32'h0);
      expect_out("st_rsv", 32'hCAFE_F00D, 1'b0, 1'b1);
      drive(1'b0, 1'b0, SZ_W, 1'b0, 16'h0010, 32'h0);
      expect_out("err_one_cycle", 32'hCAFE_F00D, 1'b0, 1'b0);

      // Inputs ignored without req_valid
      drive(1'b0, 1'b1, SZ_W, 1'b0, 16'h0010, 32'h0000_0000);
      expect_out("no_valid_st", 32'hCAFE_F00D, 1'b0, 1'b0);
      drive(1'b1, 1'b0, SZ_W, 1'b0, 16'h0010, 32'h0);
      expect_out("ld_w10_after_idle", 32'hDEAD_BEEF, 1'b1, 1'b0);

      // Top of storage
      drive(1'b1, 1'b1, SZ_W, 1'b0, 16'hFFFC, 32'h89AB_CDEF);
      drive(1'b1, 1'b0, SZ_B, 1'b0, 16'hFFFF, 32'h0);
      expect_out("ld_bFFFF_s", 32'hFFFF_FF89, 1'b1, 1'b0);
      drive(1'b1, 1'b0, SZ_H, 1'b1, 16'hFFFE, 32'h0);
      expect_out("ld_hFFFE_u", 32'h0000_89AB, 1'b1, 1'b0);

      // Request during reset is dropped; storage survives reset
      rst = 1'b1;
      drive(1'b1, 1'b1, SZ_B, 1'b0, 16'h0020, 32'h0000_00A5);
      expect_out("rst_store", 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b0, 1'b0, SZ_B, 1'b0, 16'h0000, 32'h0);
      expect_out("post_rst_idle", 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, SZ_B, 1'b1, 16'h0020, 32'h0);
      expect_out("ld_b20_kept", 32'h0000_005A, 1'b1, 1'b0);
      drive(1'b1, 1'b0, SZ_W, 1'b0, 16'h0010, 32'h0);
      expect_out("ld_w10_kept", 32'hDEAD_BEEF, 1'b1, 1'b0);
      drive(1'b0, 1'b0, SZ_B, 1'b0, 16'h0000, 32'h0);
      expect_out("final_idle", 32'hDEAD_BEEF, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_byte_datamem

// File: doc/byte_datamem.md
BYTE_DATAMEM -- requirements
Module: byte_datamem

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, byte-address width; storage is 2**ADDRESS_WIDTH bytes.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data port width; only 32 is supported and any other value SHALL fail elaboration.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present this cycle.
REQ-006 SHALL have port wr_en  input  1  1 = store, 0 = load; sampled only when req_valid=1.
REQ-007 SHALL have port size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port unsigned_ld  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port addr  input  ADDRESS_WIDTH  byte address.
REQ-010 SHALL have port wd  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port rd  output  DATA_WIDTH  registered, extended load data.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse marking rd as new.
REQ-013 SHALL have port err  output  1  one-cycle pulse: previous request misaligned or reserved size.

Function
REQ-014 SHALL accept a request on every rising edge where req_valid=1 and rst=0; no back-pressure; one request per cycle.
REQ-015 SHALL treat a request as erroneous when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-016 SHALL, for a valid store, write the 1, 2 or 4 low bytes of wd to addresses addr..addr+size_bytes-1, little-endian (wd[7:0] at addr).
REQ-017 SHALL never modify storage for an erroneous request.
REQ-018 SHALL, for a valid load, present in rd on the next cycle the little-endian bytes from addr, extended per unsigned_ld to 32 bits (load latency 1 cycle).
REQ-019 SHALL ignore unsigned_ld for word loads.
REQ-020 SHALL assert rd_valid for exactly one cycle, the cycle after a valid load is accepted; never for stores or erroneous requests.
REQ-021 SHALL assert err for exactly one cycle, the cycle after an erroneous request, load or store.
REQ-022 SHALL hold rd unchanged in all cycles without a new valid load, including after stores and errors.
REQ-023 SHALL return the newly written data for a load issued in the cycle immediately after a store to an overlapping address (no stale read).
REQ-024 SHALL wrap no addresses: a valid aligned access never crosses the top of storage, so no wrap logic exists.
REQ-025 SHALL ignore wr_en, size, unsigned_ld, addr and wd when req_valid=0; no storage change, no pulses.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, set rd=0, rd_valid=0 and err=0.
REQ-027 SHALL drop any request presented in a reset cycle: no write, and no rd_valid or err pulse after reset.
REQ-028 SHALL not initialise storage on reset; contents are preserved across reset.

Structure
REQ-029 SHALL take from shared package datamem_pkg: typedef enum mem_size_t (SIZE_B=00, SIZE_H=01, SIZE_W=10, SIZE_RSV=11) and constant WORD_BYTES=4.
REQ-030 SHALL place load-data extraction and sign/zero extension in one combinational sub-module, load_extend (inputs: raw word, addr[1:0], size, unsigned_ld; output: 32-bit value).
REQ-031 SHALL organise storage as four byte-lane arrays of 2**(ADDRESS_WIDTH-2) entries each, indexed by addr[ADDRESS_WIDTH-1:2] and written with per-lane enables.

Verification
REQ-032 Store word 0xDEADBEEF @0x10, then load word @0x10 -> next cycle rd=0xDEADBEEF, rd_valid=1 for one cycle.
REQ-033 Load byte @0x13, signed then unsigned, after REQ-032 -> rd=0xFFFFFFDE, then rd=0x000000DE.
REQ-034 Store half 0x1234 @0x12, then load word @0x10 in the following cycle -> rd=0x1234BEEF.
REQ-035 Load half @0x11, then store word @0x16 -> err pulses after each request, rd_valid stays 0, rd holds its prior value, and a word load @0x14 still returns its pre-store contents.
REQ-036 Request size=11 -> err=1 for one cycle; no storage change.
REQ-037 Assert rst together with a store of 0xA5 byte @0x20 -> rd=0, no pulses, and a later byte load @0x20 returns the old contents; data stored @0x10 before reset is still 0xDEADBEEF.
